// File: rtl/rob_multi_commit_if.sv
// ============================================================================
// Module      : rob_multi_commit_if
// Description : Bundle of signals between the reorder buffer and its
//               neighbours: issue stage, writeback channels, operand lookup,
//               and the retirement side (register file, store buffer,
//               predictor, flush).
//               master = issue/writeback/consumer side, slave = the ROB.
// Ports (slave view)
//   in : issue_valid/opcode/value_ready/value/rd_id, wb_valid/tag/value,
//        query_tag_rs1/rs2
//   out: issue_tag, full, count, query_ready/value_rs1/rs2,
//        commit_reg_valid/id/value/tag, commit_store_valid/tag,
//        predictor_signal/branch/addr, clear_signal, correct_pc
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rob_multi_commit_if #(
    parameter int ROB_WIDTH    = 4,
    parameter int WB_PORTS     = 3,
    parameter int COMMIT_WIDTH = 2,
    parameter int LOCAL_WIDTH  = 6
);
    // issue
    logic                             issue_valid;
    logic [1:0]                       issue_opcode;
    logic                             issue_value_ready;
    logic [31:0]                      issue_value;
    logic [4:0]                       issue_rd_id;
    logic [ROB_WIDTH-1:0]             issue_tag;
    logic                             full;
    logic [ROB_WIDTH:0]               count;
    // writeback
    logic [WB_PORTS-1:0]              wb_valid;
    logic [WB_PORTS*ROB_WIDTH-1:0]    wb_tag;
    logic [WB_PORTS*32-1:0]           wb_value;
    // operand lookup
    logic [ROB_WIDTH-1:0]             query_tag_rs1;
    logic [ROB_WIDTH-1:0]             query_tag_rs2;
    logic                             query_ready_rs1;
    logic                             query_ready_rs2;
    logic [31:0]                      query_value_rs1;
    logic [31:0]                      query_value_rs2;
    // retirement
    logic [COMMIT_WIDTH-1:0]          commit_reg_valid;
    logic [COMMIT_WIDTH*5-1:0]        commit_reg_id;
    logic [COMMIT_WIDTH*32-1:0]       commit_reg_value;
    logic [COMMIT_WIDTH*ROB_WIDTH-1:0] commit_reg_tag;
    logic                             commit_store_valid;
    logic [ROB_WIDTH-1:0]             commit_store_tag;
    logic                             predictor_signal;
    logic                             predictor_branch;
    logic [LOCAL_WIDTH-1:0]           predictor_addr;
    logic                             clear_signal;
    logic [31:0]                      correct_pc;

    modport master (
        output issue_valid, issue_opcode, issue_value_ready, issue_value, issue_rd_id,
        output wb_valid, wb_tag, wb_value, query_tag_rs1, query_tag_rs2,
        input  issue_tag, full, count, query_ready_rs1, query_ready_rs2,
        input  query_value_rs1, query_value_rs2,
        input  commit_reg_valid, commit_reg_id, commit_reg_value, commit_reg_tag,
        input  commit_store_valid, commit_store_tag,
        input  predictor_signal, predictor_branch, predictor_addr, clear_signal, correct_pc
    );

    modport slave (
        input  issue_valid, issue_opcode, issue_value_ready, issue_value, issue_rd_id,
        input  wb_valid, wb_tag, wb_value, query_tag_rs1, query_tag_rs2,
        output issue_tag, full, count, query_ready_rs1, query_ready_rs2,
        output query_value_rs1, query_value_rs2,
        output commit_reg_valid, commit_reg_id, commit_reg_value, commit_reg_tag,
        output commit_store_valid, commit_store_tag,
        output predictor_signal, predictor_branch, predictor_addr, clear_signal, correct_pc
    );
endinterface

`default_nettype wire

// File: rtl/rob_multi_commit.sv
// ============================================================================
// Module      : rob_multi_commit
// Description : Reorder buffer with in-order issue, out-of-order completion on
//               WB_PORTS writeback channels and in-order retirement of up to
//               COMMIT_WIDTH entries per cycle. Drives mispredict recovery and
//               bypasses writeback results to the operand lookup.
// Ports
//   clk_in  : clock, rising edge
//   rst_in  : asynchronous reset, active low
//   rdy_in  : 0 freezes every register
//   bus     : rob_multi_commit_if.slave (issue, writeback, lookup, retire)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rob_multi_commit #(
    parameter int ROB_WIDTH    = 4,
    parameter int WB_PORTS     = 3,
    parameter int COMMIT_WIDTH = 2,
    parameter int LOCAL_WIDTH  = 6
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    rob_multi_commit_if.slave    bus
);
    localparam int                  c_ROB_SIZE   = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0]  c_CNT_FULL   = (ROB_WIDTH+1)'(c_ROB_SIZE);
    localparam logic [ROB_WIDTH:0]  c_CNT_ALMOST = c_CNT_FULL - (ROB_WIDTH+1)'(1);
    localparam logic [1:0]          c_OP_REG     = 2'b00;
    localparam logic [1:0]          c_OP_STORE   = 2'b01;
    localparam logic [1:0]          c_OP_BRANCH  = 2'b10;
    localparam logic [1:0]          c_OP_LOAD    = 2'b11;
    localparam logic [31:0]         c_PC_MASK    = 32'h0003_FFFC;

    // entry state
    logic [c_ROB_SIZE-1:0]  r_busy;
    logic [c_ROB_SIZE-1:0]  r_ready;
    logic [1:0]             r_opcode [c_ROB_SIZE];
    logic [4:0]             r_rd     [c_ROB_SIZE];
    logic [31:0]            r_value  [c_ROB_SIZE];
    logic [ROB_WIDTH-1:0]   r_head;
    logic [ROB_WIDTH-1:0]   r_tail;
    logic [ROB_WIDTH:0]     r_count;

    // registered retirement outputs
    logic [COMMIT_WIDTH-1:0]           r_commit_reg_valid;
    logic [COMMIT_WIDTH*5-1:0]         r_commit_reg_id;
    logic [COMMIT_WIDTH*32-1:0]        r_commit_reg_value;
    logic [COMMIT_WIDTH*ROB_WIDTH-1:0] r_commit_reg_tag;
    logic                              r_commit_store_valid;
    logic [ROB_WIDTH-1:0]              r_commit_store_tag;
    logic                              r_predictor_signal;
    logic                              r_predictor_branch;
    logic [LOCAL_WIDTH-1:0]            r_predictor_addr;
    logic                              r_clear_signal;
    logic [31:0]                       r_correct_pc;

    logic                   w_issue_acc;
    logic [ROB_WIDTH-1:0]   w_wb_tag [WB_PORTS];
    logic [31:0]            w_wb_val [WB_PORTS];
    logic [WB_PORTS-1:0]    w_wb_ok;
    logic [COMMIT_WIDTH-1:0] w_ret;
    logic [ROB_WIDTH-1:0]   w_slot [COMMIT_WIDTH];
    logic [ROB_WIDTH:0]     w_nret;
    logic                   w_q1_rdy;
    logic                   w_q2_rdy;
    logic [31:0]            w_q1_val;
    logic [31:0]            w_q2_val;

    // An issue at a completely full buffer is ignored; at ROB_SIZE-1 it is
    // still accepted but back-pressure is raised combinationally.
    assign w_issue_acc = bus.issue_valid && (r_count != c_CNT_FULL);
    assign bus.full    = (r_count == c_CNT_FULL) || ((r_count == c_CNT_ALMOST) && bus.issue_valid);
    assign bus.issue_tag = r_tail;
    assign bus.count     = r_count;

    generate
        for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_unpack
            assign w_wb_tag[p] = bus.wb_tag[p*ROB_WIDTH +: ROB_WIDTH];
            assign w_wb_val[p] = bus.wb_value[p*32 +: 32];
            // only an outstanding (busy, not yet complete) entry accepts a result
            assign w_wb_ok[p]  = bus.wb_valid[p] && r_busy[w_wb_tag[p]] && !r_ready[w_wb_tag[p]];
        end
    endgenerate

    // Retirement group: contiguous ready entries from head. A store or branch
    // closes the group so at most one of each retires per cycle.
    always_comb begin
        logic v_stop;
        v_stop = 1'b0;
        w_ret  = '0;
        w_nret = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            w_slot[k] = r_head + ROB_WIDTH'(k);
            if (!v_stop && r_busy[w_slot[k]] && r_ready[w_slot[k]]) begin
                w_ret[k] = 1'b1;
                w_nret   = w_nret + (ROB_WIDTH+1)'(1);
                v_stop   = (r_opcode[w_slot[k]] == c_OP_STORE) || (r_opcode[w_slot[k]] == c_OP_BRANCH);
            end else begin
                v_stop = 1'b1;
            end
        end
    end

    // Operand lookup; a same-cycle writeback bypasses the stored entry.
    // Scanning from the highest port down lets the lowest port win.
    always_comb begin
        w_q1_rdy = r_busy[bus.query_tag_rs1] && r_ready[bus.query_tag_rs1];
        w_q1_val = r_value[bus.query_tag_rs1];
        w_q2_rdy = r_busy[bus.query_tag_rs2] && r_ready[bus.query_tag_rs2];
        w_q2_val = r_value[bus.query_tag_rs2];
        for (int p = WB_PORTS-1; p >= 0; p--) begin
            if (bus.wb_valid[p] && (w_wb_tag[p] == bus.query_tag_rs1)) begin
                w_q1_rdy = 1'b1;
                w_q1_val = w_wb_val[p];
            end
            if (bus.wb_valid[p] && (w_wb_tag[p] == bus.query_tag_rs2)) begin
                w_q2_rdy = 1'b1;
                w_q2_val = w_wb_val[p];
            end
        end
    end

    assign bus.query_ready_rs1 = w_q1_rdy;
    assign bus.query_value_rs1 = w_q1_val;
    assign bus.query_ready_rs2 = w_q2_rdy;
    assign bus.query_value_rs2 = w_q2_val;

    // Control state and registered outputs. A flush edge behaves exactly like
    // reset and discards that cycle's issue, writeback and retirement.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy <= '0;  r_ready <= '0;
            r_head <= '0;  r_tail  <= '0;  r_count <= '0;
            r_commit_reg_valid <= '0;  r_commit_reg_id <= '0;
            r_commit_reg_value <= '0;  r_commit_reg_tag <= '0;
            r_commit_store_valid <= 1'b0;  r_commit_store_tag <= '0;
            r_predictor_signal <= 1'b0;  r_predictor_branch <= 1'b0;
            r_predictor_addr <= '0;  r_clear_signal <= 1'b0;  r_correct_pc <= '0;
        end else if (rdy_in && r_clear_signal) begin
            r_busy <= '0;  r_ready <= '0;
            r_head <= '0;  r_tail  <= '0;  r_count <= '0;
            r_commit_reg_valid <= '0;  r_commit_reg_id <= '0;
            r_commit_reg_value <= '0;  r_commit_reg_tag <= '0;
            r_commit_store_valid <= 1'b0;  r_commit_store_tag <= '0;
            r_predictor_signal <= 1'b0;  r_predictor_branch <= 1'b0;
            r_predictor_addr <= '0;  r_clear_signal <= 1'b0;  r_correct_pc <= '0;
        end else if (rdy_in) begin
            r_commit_store_valid <= 1'b0;
            r_commit_store_tag   <= '0;
            r_predictor_signal   <= 1'b0;
            r_predictor_branch   <= 1'b0;
            r_predictor_addr     <= '0;
            r_clear_signal       <= 1'b0;
            r_correct_pc         <= '0;
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (w_ret[k] && ((r_opcode[w_slot[k]] == c_OP_REG) || (r_opcode[w_slot[k]] == c_OP_LOAD))) begin
                    r_commit_reg_valid[k]                   <= 1'b1;
                    r_commit_reg_id[k*5 +: 5]               <= r_rd[w_slot[k]];
                    r_commit_reg_value[k*32 +: 32]          <= r_value[w_slot[k]];
                    r_commit_reg_tag[k*ROB_WIDTH +: ROB_WIDTH] <= w_slot[k];
                end else begin
                    r_commit_reg_valid[k]                   <= 1'b0;
                    r_commit_reg_id[k*5 +: 5]               <= '0;
                    r_commit_reg_value[k*32 +: 32]          <= '0;
                    r_commit_reg_tag[k*ROB_WIDTH +: ROB_WIDTH] <= '0;
                end
                if (w_ret[k]) begin
                    r_busy[w_slot[k]]  <= 1'b0;
                    r_ready[w_slot[k]] <= 1'b0;
                    if (r_opcode[w_slot[k]] == c_OP_STORE) begin
                        r_commit_store_valid <= 1'b1;
                        r_commit_store_tag   <= w_slot[k];
                    end
                    if (r_opcode[w_slot[k]] == c_OP_BRANCH) begin
                        r_predictor_signal <= 1'b1;
                        r_predictor_branch <= r_value[w_slot[k]][0];
                        r_predictor_addr   <= r_value[w_slot[k]][31 -: LOCAL_WIDTH];
                        // bit 1 = predicted, bit 0 = resolved outcome
                        if (r_value[w_slot[k]][1] ^ r_value[w_slot[k]][0]) begin
                            r_clear_signal <= 1'b1;
                            r_correct_pc   <= r_value[w_slot[k]] & c_PC_MASK;
                        end
                    end
                end
            end
            for (int p = WB_PORTS-1; p >= 0; p--) begin
                if (w_wb_ok[p]) begin
                    r_ready[w_wb_tag[p]] <= 1'b1;
                end
            end
            // the tail entry is never busy when accepted, so this cannot
            // collide with the retirement or writeback updates above
            if (w_issue_acc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= bus.issue_value_ready;
            end
            r_head  <= r_head + w_nret[ROB_WIDTH-1:0];
            r_tail  <= r_tail + ROB_WIDTH'(w_issue_acc);
            r_count <= r_count + (ROB_WIDTH+1)'(w_issue_acc) - w_nret;
        end
    end

    // Entry payload needs no reset: it is only observed while busy is set.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !r_clear_signal) begin
            for (int p = WB_PORTS-1; p >= 0; p--) begin
                if (w_wb_ok[p]) begin
                    if (r_opcode[w_wb_tag[p]] == c_OP_BRANCH) begin
                        r_value[w_wb_tag[p]][0] <= w_wb_val[p][0];
                    end else begin
                        r_value[w_wb_tag[p]] <= w_wb_val[p];
                    end
                end
            end
            if (w_issue_acc) begin
                r_opcode[r_tail] <= bus.issue_opcode;
                r_rd[r_tail]     <= bus.issue_rd_id;
                r_value[r_tail]  <= bus.issue_value;
            end
        end
    end

    assign bus.commit_reg_valid   = r_commit_reg_valid;
    assign bus.commit_reg_id      = r_commit_reg_id;
    assign bus.commit_reg_value   = r_commit_reg_value;
    assign bus.commit_reg_tag     = r_commit_reg_tag;
    assign bus.commit_store_valid = r_commit_store_valid;
    assign bus.commit_store_tag   = r_commit_store_tag;
    assign bus.predictor_signal   = r_predictor_signal;
    assign bus.predictor_branch   = r_predictor_branch;
    assign bus.predictor_addr     = r_predictor_addr;
    assign bus.clear_signal       = r_clear_signal;
    assign bus.correct_pc         = r_correct_pc;

endmodule

`default_nettype wire

// File: tb/tb_rob_multi_commit.sv
// ============================================================================
// Module      : tb_rob_multi_commit
// Description : Self-checking bench for rob_multi_commit. Expected retirements
//               are queued when instructions are issued and popped as the DUT
//               retires them; directed sequences cover the corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rob_multi_commit;
    localparam int RW = 4;
    localparam int WP = 3;
    localparam int CW = 2;
    localparam int LW = 6;
    localparam logic [1:0] OP_REG = 2'b00, OP_STORE = 2'b01, OP_BRANCH = 2'b10, OP_LOAD = 2'b11;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic rdy   = 1'b1;
    always #5 clk = ~clk;

    rob_multi_commit_if #(.ROB_WIDTH(RW), .WB_PORTS(WP), .COMMIT_WIDTH(CW), .LOCAL_WIDTH(LW)) bus ();

    rob_multi_commit #(.ROB_WIDTH(RW), .WB_PORTS(WP), .COMMIT_WIDTH(CW), .LOCAL_WIDTH(LW)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .rdy_in (rdy),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [4:0] rd; logic [31:0] val; logic [RW-1:0] tag; } reg_exp_t;
    typedef struct packed { logic br; logic [LW-1:0] addr; logic clr; logic [31:0] pc; } br_exp_t;
    reg_exp_t       q_reg[$];
    logic [RW-1:0]  q_st[$];
    br_exp_t        q_br[$];
    logic [RW-1:0]  tb_tail = '0;

    typedef struct {
        logic [1:0]  op;
        logic        vr;
        logic [31:0] ival;
        logic [4:0]  rd;
        int          port;
        logic [31:0] wbv;
        logic [31:0] exp_val;
        logic        exp_br;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // retirement monitor, sampled after the outputs settle
    always @(posedge clk) begin
        #2;
        for (int k = 0; k < CW; k++) begin
            if (bus.commit_reg_valid[k] === 1'b1) begin
                if (q_reg.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_reg_commit: slot %0d rd %0h", k, bus.commit_reg_id[k*5 +: 5]);
                end else begin
                    reg_exp_t e;
                    e = q_reg.pop_front();
                    chk("reg_rd",  bus.commit_reg_id[k*5 +: 5], e.rd);
                    chk("reg_val", bus.commit_reg_value[k*32 +: 32], e.val);
                    chk("reg_tag", bus.commit_reg_tag[k*RW +: RW], e.tag);
                end
            end
        end
        if (bus.commit_store_valid === 1'b1) begin
            if (q_st.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_store_commit: tag %0h", bus.commit_store_tag);
            end else begin
                chk("store_tag", bus.commit_store_tag, q_st.pop_front());
            end
        end
        if (bus.predictor_signal === 1'b1) begin
            if (q_br.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_branch_commit: addr %0h", bus.predictor_addr);
            end else begin
                br_exp_t b;
                b = q_br.pop_front();
                chk("pred_branch", bus.predictor_branch, b.br);
                chk("pred_addr", bus.predictor_addr, b.addr);
                chk("clear", bus.clear_signal, b.clr);
                if (b.clr) chk("correct_pc", bus.correct_pc, b.pc);
            end
        end
    end

    task automatic idle_inputs();
        bus.issue_valid = 1'b0; bus.issue_opcode = '0; bus.issue_value_ready = 1'b0;
        bus.issue_value = '0;   bus.issue_rd_id = '0;
        bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_value = '0;
        bus.query_tag_rs1 = '0; bus.query_tag_rs2 = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tb_tail = '0;
    endtask

    // called at a negedge, returns at the following negedge
    task automatic issue(input logic [1:0] op, input logic vr, input logic [31:0] v, input logic [4:0] rd);
        chk("issue_tag", bus.issue_tag, tb_tail);
        bus.issue_valid = 1'b1; bus.issue_opcode = op; bus.issue_value_ready = vr;
        bus.issue_value = v;    bus.issue_rd_id = rd;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        tb_tail = tb_tail + 1'b1;
    endtask

    task automatic wb(input int p, input logic [RW-1:0] tag, input logic [31:0] v);
        bus.wb_valid[p] = 1'b1;
        bus.wb_tag[p*RW +: RW] = tag;
        bus.wb_value[p*32 +: 32] = v;
        @(negedge clk);
        bus.wb_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_reg.size() + q_st.size() + q_br.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((q_reg.size() + q_st.size() + q_br.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout: pending reg %0d store %0d branch %0d expected 0",
                     q_reg.size(), q_st.size(), q_br.size());
            q_reg.delete(); q_st.delete(); q_br.delete();
        end
        chk("count_after_drain", bus.count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bval;
        idle_inputs();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_count", bus.count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_tag", bus.issue_tag, 0);
        chk("rst_reg_valid", bus.commit_reg_valid, 0);
        chk("rst_store", bus.commit_store_valid, 0);
        chk("rst_pred", bus.predictor_signal, 0);
        chk("rst_clear", bus.clear_signal, 0);
        chk("rst_pc", bus.correct_pc, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- table-driven single instructions ----------------
        tbl[0] = '{OP_REG,    1'b1, 32'h1111_0000, 5'd1,  0, 32'h0,         32'h1111_0000, 1'b0};
        tbl[1] = '{OP_LOAD,   1'b0, 32'h0,         5'd2,  2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{OP_STORE,  1'b0, 32'h0,         5'd0,  1, 32'h0000_1234, 32'h0,         1'b0};
        tbl[3] = '{OP_REG,    1'b0, 32'h5,         5'd31, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        tbl[4] = '{OP_BRANCH, 1'b0, {6'd3, 24'h000123, 1'b1, 1'b0}, 5'd0, 0, 32'h0000_0001, 32'h0, 1'b1};
        tbl[5] = '{OP_LOAD,   1'b0, 32'h0,         5'd7,  2, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0};
        tbl[6] = '{OP_BRANCH, 1'b0, {6'd63, 24'h0, 1'b0, 1'b1}, 5'd0, 2, 32'hFFFF_FFFE, 32'h0, 1'b0};
        tbl[7] = '{OP_REG,    1'b1, 32'h0BAD_F00D, 5'd9,  0, 32'h0,         32'h0BAD_F00D, 1'b0};
        for (int i = 0; i < 8; i++) begin
            logic [RW-1:0] t;
            t = tb_tail;
            case (tbl[i].op)
                OP_STORE:  q_st.push_back(t);
                OP_BRANCH: q_br.push_back('{tbl[i].exp_br, tbl[i].ival[31:26], 1'b0, 32'h0});
                default:   q_reg.push_back('{tbl[i].rd, tbl[i].exp_val, t});
            endcase
            issue(tbl[i].op, tbl[i].vr, tbl[i].ival, tbl[i].rd);
            if (!tbl[i].vr) wb(tbl[i].port, t, tbl[i].wbv);
        end
        drain();

        // ---------------- two REGs retire together ----------------
        do_reset();
        q_reg.push_back('{5'd10, 32'hAAAA_0000, 4'd0});
        q_reg.push_back('{5'd11, 32'hBBBB_0001, 4'd1});
        issue(OP_REG, 1'b0, 32'h0, 5'd10);
        issue(OP_REG, 1'b0, 32'h0, 5'd11);
        wb(0, 4'd1, 32'hBBBB_0001);
        wb(1, 4'd0, 32'hAAAA_0000);
        @(negedge clk);
        chk("dual_valid", bus.commit_reg_valid, 2'b11);
        drain();

        // ---------------- same tag on two ports + bypass ----------------
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q_reg.push_back('{5'(i + 1), (i == 3) ? 32'd7 : 32'h100 + 32'(i), 4'(i)});
            issue(OP_REG, 1'b0, 32'h0, 5'(i + 1));
        end
        bus.wb_valid = 3'b101;
        bus.wb_tag[0 +: RW] = 4'd3;       bus.wb_value[0 +: 32] = 32'd7;
        bus.wb_tag[2*RW +: RW] = 4'd3;    bus.wb_value[64 +: 32] = 32'd9;
        bus.query_tag_rs1 = 4'd3;
        bus.query_tag_rs2 = 4'd2;
        #1;
        chk("fwd_ready", bus.query_ready_rs1, 1);
        chk("fwd_value", bus.query_value_rs1, 32'd7);
        chk("fwd_rs2_not_ready", bus.query_ready_rs2, 0);
        @(negedge clk);
        bus.wb_valid = '0;
        #1;
        chk("stored_ready", bus.query_ready_rs1, 1);
        chk("stored_value", bus.query_value_rs1, 32'd7);
        for (int i = 0; i < 3; i++) wb(1, 4'(i), 32'h100 + 32'(i));
        drain();

        // ---------------- store closes the retirement group ----------------
        do_reset();
        q_st.push_back(4'd0);
        q_reg.push_back('{5'd5, 32'h55, 4'd1});
        issue(OP_STORE, 1'b0, 32'h0, 5'd0);
        issue(OP_REG, 1'b1, 32'h55, 5'd5);
        wb(0, 4'd0, 32'h99);
        @(negedge clk);
        chk("st_c1_store", bus.commit_store_valid, 1);
        chk("st_c1_reg", bus.commit_reg_valid, 2'b00);
        @(negedge clk);
        chk("st_c2_store", bus.commit_store_valid, 0);
        chk("st_c2_reg", bus.commit_reg_valid, 2'b01);
        drain();

        // ---------------- branch mispredict and flush ----------------
        do_reset();
        bval = {6'd5, 24'h000040, 1'b1, 1'b0};
        q_br.push_back('{1'b0, 6'd5, 1'b1, 32'h0000_0100});
        issue(OP_BRANCH, 1'b0, bval, 5'd0);
        issue(OP_REG, 1'b1, 32'h77, 5'd3);   // younger than the branch, must be flushed
        wb(1, 4'd0, 32'hFFFF_FFF0);
        @(negedge clk);
        chk("br_clear", bus.clear_signal, 1);
        chk("br_pc", bus.correct_pc, 32'h0000_0100);
        chk("br_count", bus.count, 1);
        @(negedge clk);
        chk("flush_count", bus.count, 0);
        chk("flush_clear", bus.clear_signal, 0);
        chk("flush_tag", bus.issue_tag, 0);
        tb_tail = '0;
        repeat (3) @(negedge clk);
        drain();

        // ---------------- fill to full ----------------
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_opcode = OP_REG; bus.issue_value_ready = 1'b0;
        bus.issue_rd_id = 5'd1;
        for (int i = 0; i <= 16; i++) begin
            logic exp_full;
            exp_full = (i >= 15);
            #1;
            chk("fill_full", bus.full, exp_full);
            chk("fill_count", bus.count, i);
            if (i < 16) chk("fill_tag", bus.issue_tag, i % 16);
            @(negedge clk);
        end
        bus.issue_valid = 1'b0;
        #1;
        chk("fill_count_end", bus.count, 16);
        chk("fill_tag_wrap", bus.issue_tag, 0);
        chk("fill_full_end", bus.full, 1);
        @(negedge clk);

        // ---------------- freeze, then reset mid-traffic ----------------
        do_reset();
        for (int i = 0; i < 5; i++) issue(OP_REG, 1'b0, 32'h0, 5'(i + 1));
        chk("pre_rst_count", bus.count, 5);
        rdy = 1'b0;
        bus.issue_valid = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        rdy = 1'b1;
        chk("frozen_count", bus.count, 5);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_count", bus.count, 0);
        chk("async_rst_tag", bus.issue_tag, 0);
        chk("async_rst_full", bus.full, 0);
        chk("async_rst_reg_valid", bus.commit_reg_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tb_tail = '0;
        wb(0, 4'd0, 32'h1);
        wb(1, 4'd1, 32'h2);
        repeat (4) @(negedge clk);
        chk("post_rst_count", bus.count, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
